// File: rtl/plazer_st_pkg.sv
// Shared definitions for the plazer streaming adapters: default sizes,
// the fill-level width helper and the saturating counter increment.
package plazer_st_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4;

  // Width of a fill level able to hold 0..depth inclusive.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] lim;
    lim = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= lim) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/plazer_st_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port and one
// asynchronous read port. Storage carries no reset.
module plazer_st_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write the accepted word into its slot.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/plazer_st_timing_fifo_adt.sv
// Avalon-ST timing adapter: absorbs downstream backpressure in a show-ahead
// FIFO for a source that cannot stall. Words arriving while full are dropped
// and counted in a sticky flag and a saturating counter.
module plazer_st_timing_fifo_adt
  import plazer_st_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   almost_full,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_count,
  input  logic                   clr_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = level_w(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] AF_LVL   = LVL_W'(AF_LEVEL);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic [LVL_W-1:0] count_nxt;
  logic             push;
  logic             pop;
  logic             drop;
  logic [31:0]      drop_inc;

  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign pop       = out_valid & out_ready;
  assign push      = in_valid & ((count < FULL_LVL) | pop);
  assign drop      = in_valid & ~push;
  assign out_valid = (count != '0);
  assign in_ready  = (count < FULL_LVL) | out_ready;
  assign fill_level = count;
  assign drop_inc  = sat_inc(32'(drop_count), CNT_W);

  // Next occupancy; simultaneous push and pop cancel out.
  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (pop && !push) count_nxt = count - 1'b1;
  end

  // Pointers, occupancy and almost_full, which tracks the next occupancy so
  // it lines up with fill_level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count       <= count_nxt;
      almost_full <= (count_nxt >= AF_LVL);
    end
  end

  // Overflow flag and drop counter; a drop in the clearing cycle wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clr_overflow) begin
      overflow   <= drop;
      drop_count <= drop ? CNT_W'(1) : '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      drop_count <= drop_inc[CNT_W-1:0];
    end
  end

  plazer_st_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (out_data)
  );

endmodule

// File: tb/tb_plazer_st_timing_fifo_adt.sv
// Bench for plazer_st_timing_fifo_adt: a queue-based model of the adapter
// drives expectations; a second instance with a 2-bit drop counter covers
// counter saturation.
module tb_plazer_st_timing_fifo_adt;

  localparam int DEPTH = 4;
  localparam int AF    = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       out_ready = 1'b0;
  logic       clr_overflow = 1'b0;

  logic        in_ready, out_valid, almost_full, overflow;
  logic [7:0]  out_data;
  logic [2:0]  fill_level;
  logic [15:0] drop_count;

  logic        s_in_ready, s_out_valid, s_almost_full, s_overflow;
  logic [7:0]  s_out_data;
  logic [2:0]  s_fill_level;
  logic [1:0]  s_drop_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] q[$];
  bit         m_af, m_ovf;
  int         m_cnt16, m_cnt2;

  // Per-cycle observations and expectations
  bit         obs_pop, exp_pop, obs_in_ready, exp_in_ready;
  logic [7:0] obs_data, exp_data;

  always #5 clk = ~clk;

  plazer_st_timing_fifo_adt #(.DATA_W(8), .DEPTH(DEPTH), .AF_LEVEL(AF), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .fill_level(fill_level), .almost_full(almost_full),
    .overflow(overflow), .drop_count(drop_count), .clr_overflow(clr_overflow)
  );

  plazer_st_timing_fifo_adt #(.DATA_W(8), .DEPTH(DEPTH), .AF_LEVEL(AF), .CNT_W(2)) dut_s (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(s_in_ready), .out_valid(s_out_valid), .out_data(s_out_data),
    .out_ready(out_ready), .fill_level(s_fill_level), .almost_full(s_almost_full),
    .overflow(s_overflow), .drop_count(s_drop_count), .clr_overflow(clr_overflow)
  );

  task automatic model_reset();
    q.delete();
    m_af = 0; m_ovf = 0; m_cnt16 = 0; m_cnt2 = 0;
  endtask

  // Drive one cycle from a negedge; sample before the rising edge, update the
  // model at the edge, and return on the following negedge.
  task automatic cycle(input logic iv, input logic [7:0] d, input logic ordy, input logic clr);
    int  sz;
    bit  pop, push, drop;
    in_valid = iv; in_data = d; out_ready = ordy; clr_overflow = clr;
    #1;
    sz = q.size();
    obs_pop = out_valid & out_ready;
    obs_data = out_data;
    obs_in_ready = in_ready;
    pop  = (sz > 0) && ordy;
    push = iv && ((sz < DEPTH) || pop);
    drop = iv && !push;
    exp_pop = pop;
    exp_data = pop ? q[0] : 8'h00;
    exp_in_ready = (sz < DEPTH) || ordy;
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(d);
    m_af = (q.size() >= AF);
    if (clr) begin
      m_ovf = drop; m_cnt16 = drop ? 1 : 0; m_cnt2 = drop ? 1 : 0;
    end else if (drop) begin
      m_ovf = 1;
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 0; clr_overflow = 0;
  endtask

  task automatic test_reset();
    reset_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (fill_level !== 3'd0) begin errors++; $display("FAIL reset_fill got %0d want 0", fill_level); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got %0b want 0", almost_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", overflow); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if (s_fill_level !== 3'd0 || s_drop_count !== 2'd0) begin errors++; $display("FAIL reset_s got fill %0d drop %0d want 0 0", s_fill_level, s_drop_count); end
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_pass_through();
    for (int i = 0; i <= 100; i++) begin
      cycle(i < 100, 8'(i), 1'b1, 1'b0);
      checks++;
      if (obs_pop !== exp_pop || (exp_pop && obs_data !== 8'(i - 1))) begin
        errors++; $display("FAIL pass_out[%0d] got v%0b d%02h want v%0b d%02h", i, obs_pop, obs_data, exp_pop, 8'(i - 1));
      end
      checks++;
      if (fill_level > 3'd1) begin errors++; $display("FAIL pass_fill[%0d] got %0d want <=1", i, fill_level); end
    end
    checks++; if (overflow !== 1'b0 || drop_count !== 16'd0) begin errors++; $display("FAIL pass_ovf got %0b/%0d want 0/0", overflow, drop_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pass_empty got %0b want 0", out_valid); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0);
      checks++; if (fill_level !== 3'(i + 1)) begin errors++; $display("FAIL fill_level[%0d] got %0d want %0d", i, fill_level, i + 1); end
      checks++; if (almost_full !== (i >= 2)) begin errors++; $display("FAIL fill_af[%0d] got %0b want %0b", i, almost_full, i >= 2); end
    end
    out_ready = 0; in_valid = 0; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %0b want 0", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hA1) begin errors++; $display("FAIL full_head got v%0b d%02h want v1 dA1", out_valid, out_data); end
  endtask

  task automatic test_overflow();
    cycle(1'b1, 8'hB0, 1'b0, 1'b0);
    cycle(1'b1, 8'hB1, 1'b0, 1'b0);
    checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL ovf_drop got %0d want 2", drop_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", overflow); end
    checks++; if (fill_level !== 3'd4 || out_data !== 8'hA1) begin errors++; $display("FAIL ovf_contents got fill %0d head %02h want 4 A1", fill_level, out_data); end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b0 || drop_count !== 16'd0) begin errors++; $display("FAIL ovf_clear got %0b/%0d want 0/0", overflow, drop_count); end
  endtask

  task automatic test_full_push_pop();
    cycle(1'b1, 8'hC0, 1'b1, 1'b0);
    checks++; if (obs_pop !== 1'b1 || obs_data !== 8'hA1) begin errors++; $display("FAIL fpp_pop got v%0b d%02h want v1 dA1", obs_pop, obs_data); end
    checks++; if (fill_level !== 3'd4) begin errors++; $display("FAIL fpp_fill got %0d want 4", fill_level); end
    checks++; if (overflow !== 1'b0 || drop_count !== 16'd0) begin errors++; $display("FAIL fpp_drop got %0b/%0d want 0/0", overflow, drop_count); end
  endtask

  task automatic test_drain();
    logic [7:0] want [4];
    want = '{8'hA2, 8'hA3, 8'hA4, 8'hC0};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++; if (obs_pop !== 1'b1 || obs_data !== want[i]) begin errors++; $display("FAIL drain[%0d] got v%0b d%02h want v1 d%02h", i, obs_pop, obs_data, want[i]); end
    end
    checks++; if (out_valid !== 1'b0 || fill_level !== 3'd0) begin errors++; $display("FAIL drain_empty got v%0b fill %0d want 0 0", out_valid, fill_level); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    checks++; if (s_drop_count !== 2'd3) begin errors++; $display("FAIL sat_cnt2 got %0d want 3", s_drop_count); end
    checks++; if (drop_count !== 16'd5) begin errors++; $display("FAIL sat_cnt16 got %0d want 5", drop_count); end
    cycle(1'b1, 8'h5A, 1'b0, 1'b1);
    checks++; if (s_drop_count !== 2'd1 || s_overflow !== 1'b1) begin errors++; $display("FAIL race_s got %0d/%0b want 1/1", s_drop_count, s_overflow); end
    checks++; if (drop_count !== 16'd1 || overflow !== 1'b1) begin errors++; $display("FAIL race got %0d/%0b want 1/1", drop_count, overflow); end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 19) == 0));
      checks++;
      if (obs_pop !== exp_pop || (exp_pop && obs_data !== exp_data) || obs_in_ready !== exp_in_ready ||
          fill_level !== 3'(q.size()) || almost_full !== m_af || overflow !== m_ovf ||
          drop_count !== 16'(m_cnt16) || s_drop_count !== 2'(m_cnt2)) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL rand[%0d] got pop%0b d%02h rdy%0b fill%0d af%0b ovf%0b dc%0d s%0d want pop%0b d%02h rdy%0b fill%0d af%0b ovf%0b dc%0d s%0d",
                   i, obs_pop, obs_data, obs_in_ready, fill_level, almost_full, overflow, drop_count, s_drop_count,
                   exp_pop, exp_data, exp_in_ready, q.size(), m_af, m_ovf, m_cnt16, m_cnt2);
      end
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (fill_level !== 3'd3 || drop_count === 16'd0) begin errors++; $display("FAIL arst_pre got fill %0d drop %0d want 3 nonzero", fill_level, drop_count); end
    #2 reset_n = 0;
    #1;
    model_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %0b want 0", out_valid); end
    checks++; if (fill_level !== 3'd0) begin errors++; $display("FAIL arst_fill got %0d want 0", fill_level); end
    checks++; if (drop_count !== 16'd0 || overflow !== 1'b0) begin errors++; $display("FAIL arst_drop got %0d/%0b want 0/0", drop_count, overflow); end
    @(negedge clk);
    reset_n = 1;
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (obs_pop !== 1'b1 || obs_data !== 8'h77) begin errors++; $display("FAIL arst_after got v%0b d%02h want v1 d77", obs_pop, obs_data); end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_fill();
    test_overflow();
    test_full_push_pop();
    test_drain();
    test_saturation();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
